// File: rtl/w1_accum.sv
// Accumulates NUM_PP consecutive W1 transform words, each weighted by 4^k,
// into one unsigned product word with valid/ready handshakes on both sides.
module w1_accum #(
    parameter  int P      = 33,
    parameter  int NUM_PP = 4,
    localparam int ACC_W  = 2 * (P + 1 + NUM_PP)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*P+1:0]     w1,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   prod,
    output logic               busy
);

    localparam int CW = $clog2(NUM_PP) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               accept;
    logic [ACC_W-1:0]   addend;

    // DONE never accepts, so readiness is purely a function of state.
    assign accept = in_valid && (state_q != S_DONE);
    assign addend = ACC_W'(w1) << {cnt_q, 1'b0};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    acc_d   = ACC_W'(w1);
                    cnt_d   = CW'(1);
                    state_d = (NUM_PP == 1) ? S_DONE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (accept) begin
                    acc_d = acc_q + addend;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(NUM_PP - 1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                acc_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decode state and the accumulator register only.
    assign in_ready  = (state_q != S_DONE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign prod      = (state_q == S_DONE) ? acc_q : '0;

endmodule

// File: tb/tb_w1_accum.sv
// Bench for w1_accum: directed scenarios on three parameterisations plus
// randomized traffic checked against a queue-and-arithmetic reference model.
module tb_w1_accum;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    // a: P=2 NUM_PP=2 (ACC_W=10)
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
    logic [5:0]  a_w1;
    logic [9:0]  a_prod;
    // b: P=33 NUM_PP=4 (ACC_W=76)
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
    logic [67:0] b_w1;
    logic [75:0] b_prod;
    // c: P=2 NUM_PP=1 (ACC_W=8)
    logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_busy;
    logic [5:0]  c_w1;
    logic [7:0]  c_prod;

    w1_accum #(.P(2), .NUM_PP(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .w1(a_w1), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .prod(a_prod), .busy(a_busy));

    w1_accum #(.P(33), .NUM_PP(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .w1(b_w1), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .prod(b_prod), .busy(b_busy));

    w1_accum #(.P(2), .NUM_PP(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .w1(c_w1), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .prod(c_prod), .busy(c_busy));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_send(input logic [5:0] w);
        a_in_valid = 1'b1;
        a_w1       = w;
        tick();
        a_in_valid = 1'b0;
        a_w1       = 6'($urandom);
    endtask

    task automatic b_send(input logic [67:0] w);
        b_in_valid = 1'b1;
        b_w1       = w;
        tick();
        b_in_valid = 1'b0;
    endtask

    // Reference: product = sum of word[k] * 4^k.
    function automatic logic [9:0] sum_a(input logic [5:0] q[$]);
        logic [9:0] s  = '0;
        logic [9:0] pw = 10'd1;
        foreach (q[k]) begin
            s  = s + 10'(q[k]) * pw;
            pw = pw * 10'd4;
        end
        return s;
    endfunction

    function automatic logic [75:0] sum_b(input logic [67:0] q[$]);
        logic [75:0] s  = '0;
        logic [75:0] pw = 76'd1;
        foreach (q[k]) begin
            s  = s + 76'(q[k]) * pw;
            pw = pw * 76'd4;
        end
        return s;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        a_in_valid = 1'b1; b_in_valid = 1'b1; c_in_valid = 1'b1;
        a_out_ready = 1'b1; b_out_ready = 1'b1; c_out_ready = 1'b1;
        a_w1 = 6'd27; b_w1 = 68'd5; c_w1 = 6'd27;
        tick();
        tick();
        rst_n = 1'b1;
        a_in_valid = 1'b0; b_in_valid = 1'b0; c_in_valid = 1'b0;
        a_out_ready = 1'b0; b_out_ready = 1'b0; c_out_ready = 1'b0;
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_a_in_ready got %0b want 1", a_in_ready); end
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_a_out_valid got %0b want 0", a_out_valid); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_a_busy got %0b want 0", a_busy); end
        checks++; if (a_prod !== 10'd0) begin errors++; $display("FAIL reset_a_prod got %0d want 0", a_prod); end
        checks++; if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0 || b_busy !== 1'b0) begin errors++; $display("FAIL reset_b_ctrl got rdy=%0b ov=%0b busy=%0b want 1/0/0", b_in_ready, b_out_valid, b_busy); end
        checks++; if (b_prod !== 76'd0) begin errors++; $display("FAIL reset_b_prod got %0h want 0", b_prod); end
        checks++; if (c_in_ready !== 1'b1 || c_out_valid !== 1'b0 || c_busy !== 1'b0) begin errors++; $display("FAIL reset_c_ctrl got rdy=%0b ov=%0b busy=%0b want 1/0/0", c_in_ready, c_out_valid, c_busy); end
        checks++; if (c_prod !== 8'd0) begin errors++; $display("FAIL reset_c_prod got %0d want 0", c_prod); end
        $display("test_reset done");
    endtask

    task automatic test_basic_a();
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready got %0b want 1", a_in_ready); end
        a_send(6'b01_10_11);
        checks++; if (a_busy !== 1'b1 || a_out_valid !== 1'b0) begin errors++; $display("FAIL basic_mid got busy=%0b ov=%0b want 1/0", a_busy, a_out_valid); end
        checks++; if (a_prod !== 10'd0) begin errors++; $display("FAIL basic_mid_prod got %0d want 0", a_prod); end
        a_send(6'b01_00_00);
        checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid got %0b want 1", a_out_valid); end
        checks++; if (a_prod !== 10'd91) begin errors++; $display("FAIL basic_prod got %0d want 91", a_prod); end
        checks++; if (a_in_ready !== 1'b0 || a_busy !== 1'b1) begin errors++; $display("FAIL basic_done got rdy=%0b busy=%0b want 0/1", a_in_ready, a_busy); end
        $display("test_basic_a prod=%0d", a_prod);
    endtask

    task automatic test_backpressure_a();
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a_w1 = 6'($urandom);
            tick();
            checks++; if (a_prod !== 10'd91 || a_out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold[%0d] got prod=%0d ov=%0b want 91/1", i, a_prod, a_out_valid); end
            checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got %0b want 0", i, a_in_ready); end
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
        checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got ov=%0b rdy=%0b want 0/1", a_out_valid, a_in_ready); end
        checks++; if (a_prod !== 10'd0 || a_busy !== 1'b0) begin errors++; $display("FAIL bp_idle got prod=%0d busy=%0b want 0/0", a_prod, a_busy); end
        $display("test_backpressure_a released");
    endtask

    task automatic test_all_threes_a();
        a_send(6'b11_11_11);
        a_send(6'b11_11_11);
        checks++; if (a_prod !== 10'd315 || a_out_valid !== 1'b1) begin errors++; $display("FAIL threes_prod got %0d ov=%0b want 315/1", a_prod, a_out_valid); end
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
        $display("test_all_threes_a prod=315 expected");
    endtask

    task automatic test_gaps_b();
        for (int k = 0; k < 4; k++) begin
            b_send(68'd1);
            if (k < 3) begin
                for (int g = 0; g < 3; g++) begin
                    checks++; if (b_out_valid !== 1'b0 || b_busy !== 1'b1) begin errors++; $display("FAIL gaps_wait[%0d.%0d] got ov=%0b busy=%0b want 0/1", k, g, b_out_valid, b_busy); end
                    tick();
                end
            end
        end
        checks++; if (b_out_valid !== 1'b1 || b_prod !== 76'd85) begin errors++; $display("FAIL gaps_prod got ov=%0b prod=%0d want 1/85", b_out_valid, b_prod); end
        b_out_ready = 1'b1;
        tick();
        b_out_ready = 1'b0;
        $display("test_gaps_b done");
    endtask

    task automatic test_reset_mid_a();
        a_send(6'd27);
        checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy got %0b want 1", a_busy); end
        rst_n      = 1'b0;
        a_in_valid = 1'b1;
        a_w1       = 6'd16;
        tick();
        rst_n      = 1'b1;
        a_in_valid = 1'b0;
        checks++; if (a_out_valid !== 1'b0 || a_busy !== 1'b0 || a_prod !== 10'd0) begin errors++; $display("FAIL rstmid_abort got ov=%0b busy=%0b prod=%0d want 0/0/0", a_out_valid, a_busy, a_prod); end
        a_send(6'd27);
        a_send(6'd16);
        checks++; if (a_out_valid !== 1'b1 || a_prod !== 10'd91) begin errors++; $display("FAIL rstmid_prod got ov=%0b prod=%0d want 1/91", a_out_valid, a_prod); end
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
        $display("test_reset_mid_a done");
    endtask

    task automatic test_num_pp_1_c();
        checks++; if (c_in_ready !== 1'b1) begin errors++; $display("FAIL npp1_ready got %0b want 1", c_in_ready); end
        c_in_valid = 1'b1;
        c_w1       = 6'b01_10_11;
        tick();
        c_in_valid = 1'b0;
        checks++; if (c_out_valid !== 1'b1 || c_prod !== 8'd27) begin errors++; $display("FAIL npp1_prod got ov=%0b prod=%0d want 1/27", c_out_valid, c_prod); end
        checks++; if (c_in_ready !== 1'b0 || c_busy !== 1'b1) begin errors++; $display("FAIL npp1_done got rdy=%0b busy=%0b want 0/1", c_in_ready, c_busy); end
        c_out_ready = 1'b1;
        tick();
        c_out_ready = 1'b0;
        checks++; if (c_out_valid !== 1'b0 || c_busy !== 1'b0) begin errors++; $display("FAIL npp1_release got ov=%0b busy=%0b want 0/0", c_out_valid, c_busy); end
        $display("test_num_pp_1_c done");
    endtask

    // Cycle-level traffic on dut_a; the model tracks accepted words and whether
    // a completed sum is waiting to be taken downstream.
    task automatic run_a(input int pv, input int pr, input int ncyc, output int done_cnt);
        logic [5:0] q[$];
        logic       pend = 1'b0;
        logic [9:0] exp_v = '0;
        done_cnt = 0;
        for (int cyc = 0; cyc < ncyc + 20; cyc++) begin
            if (cyc >= ncyc && q.size() == 0 && !pend) break;
            if (cyc >= ncyc) begin
                a_in_valid  = (q.size() > 0);
                a_out_ready = 1'b1;
            end else begin
                a_in_valid  = ($urandom_range(99) < pv);
                a_out_ready = ($urandom_range(99) < pr);
            end
            a_w1 = {2'b01, 4'($urandom)};
            checks++; if (a_out_valid !== pend || a_in_ready !== !pend) begin errors++; $display("FAIL rand_a_ctrl cyc %0d got ov=%0b rdy=%0b want %0b/%0b", cyc, a_out_valid, a_in_ready, pend, !pend); end
            checks++; if (a_prod !== (pend ? exp_v : 10'd0)) begin errors++; $display("FAIL rand_a_prod cyc %0d got %0d want %0d", cyc, a_prod, pend ? exp_v : 10'd0); end
            if (pend) begin
                if (a_out_ready) begin
                    pend = 1'b0;
                    done_cnt++;
                    $display("rand_a burst %0d prod=%0d", done_cnt, exp_v);
                end
            end else if (a_in_valid) begin
                q.push_back(a_w1);
                if (q.size() == 2) begin
                    exp_v = sum_a(q);
                    pend  = 1'b1;
                    q.delete();
                end
            end
            tick();
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b0;
        checks++; if (pend || q.size() != 0 || a_busy !== 1'b0) begin errors++; $display("FAIL rand_a_drain got pend=%0b left=%0d busy=%0b want 0/0/0", pend, q.size(), a_busy); end
    endtask

    task automatic run_b(input int ncyc);
        logic [67:0] q[$];
        logic        pend = 1'b0;
        logic [75:0] exp_v = '0;
        int          n = 0;
        for (int cyc = 0; cyc < ncyc + 40; cyc++) begin
            if (cyc >= ncyc && q.size() == 0 && !pend) break;
            if (cyc >= ncyc) begin
                b_in_valid  = (q.size() > 0);
                b_out_ready = 1'b1;
            end else begin
                b_in_valid  = ($urandom_range(99) < 70);
                b_out_ready = ($urandom_range(99) < 50);
            end
            b_w1 = {2'b01, 2'($urandom), $urandom, $urandom};
            checks++; if (b_out_valid !== pend || b_in_ready !== !pend) begin errors++; $display("FAIL rand_b_ctrl cyc %0d got ov=%0b rdy=%0b want %0b/%0b", cyc, b_out_valid, b_in_ready, pend, !pend); end
            checks++; if (b_prod !== (pend ? exp_v : 76'd0)) begin errors++; $display("FAIL rand_b_prod cyc %0d got %0h want %0h", cyc, b_prod, pend ? exp_v : 76'd0); end
            if (pend) begin
                if (b_out_ready) begin
                    pend = 1'b0;
                    n++;
                    $display("rand_b burst %0d prod=%0h", n, exp_v);
                end
            end else if (b_in_valid) begin
                q.push_back(b_w1);
                if (q.size() == 4) begin
                    exp_v = sum_b(q);
                    pend  = 1'b1;
                    q.delete();
                end
            end
            tick();
        end
        b_in_valid  = 1'b0;
        b_out_ready = 1'b0;
        checks++; if (pend || q.size() != 0 || b_busy !== 1'b0) begin errors++; $display("FAIL rand_b_drain got pend=%0b left=%0d busy=%0b want 0/0/0", pend, q.size(), b_busy); end
    endtask

    task automatic test_back_to_back_a();
        int done_cnt;
        run_a(100, 100, 30, done_cnt);
        // Full-rate traffic: two accepts then one DONE bubble per burst.
        checks++; if (done_cnt != 10) begin errors++; $display("FAIL b2b_bursts got %0d want 10", done_cnt); end
        $display("test_back_to_back_a bursts=%0d", done_cnt);
    endtask

    task automatic test_random_a();
        int done_cnt;
        run_a(60, 50, 300, done_cnt);
        $display("test_random_a bursts=%0d", done_cnt);
    endtask

    task automatic test_random_b();
        run_b(300);
        $display("test_random_b done");
    endtask

    initial begin
        a_in_valid = 1'b0; a_out_ready = 1'b0; a_w1 = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b0; b_w1 = '0;
        c_in_valid = 1'b0; c_out_ready = 1'b0; c_w1 = '0;
        rst_n = 1'b0;
        tick();
        test_reset();
        test_basic_a();
        test_backpressure_a();
        test_all_threes_a();
        test_gaps_b();
        test_reset_mid_a();
        test_num_pp_1_c();
        test_back_to_back_a();
        test_random_a();
        test_random_b();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
